// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters and sync/blank decode (optional VGA_SYNC_PIPE_DELAY_EN delays sync/blank one clock)
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 400,
    parameter int V_FRONT   = 12,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 35
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] CounterX,
    output logic [8:0] CounterY,
    output logic       hsync,
    output logic       vsync,
    output logic       inDisplayArea,
    output logic       calc_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [8:0] Y_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] Y_VIS    = 9'(V_VISIBLE);
    localparam logic [8:0] VS_START = 9'(V_VISIBLE + V_FRONT);
    localparam logic [8:0] VS_END   = 9'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] x_next;
    logic [8:0] y_next;
    logic       hs_next;
    logic       vs_next;
    logic       de_next;
    logic       cs_next;
    logic       hs_r;
    logic       vs_r;
    logic       de_r;

    // Decoding from the next counter values keeps the registered flags in step with the counters.
    always_comb begin
        x_next = CounterX + 10'd1;
        y_next = CounterY;
        if (CounterX == X_LAST) begin
            x_next = '0;
            y_next = (CounterY == Y_LAST) ? '0 : CounterY + 9'd1;
        end
        hs_next = !((x_next >= HS_START) && (x_next < HS_END));
        vs_next = (y_next >= VS_START) && (y_next < VS_END);
        de_next = (x_next < X_VIS) && (y_next < Y_VIS);
        cs_next = (x_next == 10'd0) && (y_next == Y_VIS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            CounterX   <= '0;
            CounterY   <= '0;
            hs_r       <= 1'b1;
            vs_r       <= 1'b0;
            de_r       <= 1'b1;
            calc_start <= 1'b0;
        end else begin
            CounterX   <= x_next;
            CounterY   <= y_next;
            hs_r       <= hs_next;
            vs_r       <= vs_next;
            de_r       <= de_next;
            calc_start <= cs_next;
        end
    end

`ifdef VGA_SYNC_PIPE_DELAY_EN
    // Extra stage lines sync/blank up with the registered draw output of the ball stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync         <= 1'b1;
            vsync         <= 1'b0;
            inDisplayArea <= 1'b0;
        end else begin
            hsync         <= hs_r;
            vsync         <= vs_r;
            inDisplayArea <= de_r;
        end
    end
`else
    assign hsync         = hs_r;
    assign vsync         = vs_r;
    assign inDisplayArea = de_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen, default and reduced-timing instances
module tb_vga_sync_gen;

    localparam int S_HV = 20, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VV = 10, S_VF = 3, S_VS = 2, S_VB = 4;
    localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VV + S_VF + S_VS + S_VB;
    localparam int N_CYC = 30000;
    localparam int RAND_END = 24000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [9:0] dx, sx;
    logic [8:0] dy, sy;
    logic dhs, dvs, dde, dcs, shs, svs, sde, scs;

    vga_sync_gen dut_d (
        .clock(clock), .reset(reset), .CounterX(dx), .CounterY(dy),
        .hsync(dhs), .vsync(dvs), .inDisplayArea(dde), .calc_start(dcs)
    );

    vga_sync_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_s (
        .clock(clock), .reset(reset), .CounterX(sx), .CounterY(sy),
        .hsync(shs), .vsync(svs), .inDisplayArea(sde), .calc_start(scs)
    );

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit cs;
    } exp_t;

    exp_t q_d[$];
    exp_t q_s[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Raster position is just elapsed clocks since reset, folded by line and frame length.
    function automatic exp_t model(int t, int hv, int hf, int hs, int hb,
                                   int vv, int vf, int vs, int vb);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        e.x  = t % ht;
        e.y  = (t / ht) % vt;
        e.hs = !(e.x >= hv + hf && e.x < hv + hf + hs);
        e.vs = (e.y >= vv + vf && e.y < vv + vf + vs);
        e.de = (e.x < hv && e.y < vv);
        e.cs = (e.x == 0 && e.y == vv);
        return e;
    endfunction

`ifdef VGA_SYNC_PIPE_DELAY_EN
    function automatic exp_t delay_model(exp_t cur, exp_t prev, bit rst);
        exp_t e = cur;
        if (rst) begin
            e.hs = 1'b1; e.vs = 1'b0; e.de = 1'b0;
        end else begin
            e.hs = prev.hs; e.vs = prev.vs; e.de = prev.de;
        end
        return e;
    endfunction
`endif

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus: random reset pulses (plus one directed 3-clock reset), then a reset-free tail.
    initial begin
        int t = 0;
        int rst_left = 3;
        bit rst;
        exp_t cd, cs;
`ifdef VGA_SYNC_PIPE_DELAY_EN
        exp_t pd, ps;
`endif
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            if (cyc == 7000) rst_left = 3;
            if (rst_left > 0) begin
                rst = 1'b1;
                rst_left--;
            end else if (cyc < RAND_END && $urandom_range(0, 999) < 3) begin
                rst = 1'b1;
                rst_left = $urandom_range(0, 2);
            end else begin
                rst = 1'b0;
            end
            reset = rst;
            t = rst ? 0 : t + 1;
            cd = model(t, 640, 16, 96, 48, 400, 12, 2, 35);
            cs = model(t, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
`ifdef VGA_SYNC_PIPE_DELAY_EN
            q_d.push_back(delay_model(cd, pd, rst));
            q_s.push_back(delay_model(cs, ps, rst));
            pd = cd;
            ps = cs;
`else
            q_d.push_back(cd);
            q_s.push_back(cs);
`endif
            @(negedge clock);
        end
        @(negedge clock);
        chk("scoreboard_drained", q_d.size() + q_s.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Monitor: outputs are presented every clock; pop and compare, plus run-length checks.
    initial begin
        exp_t e;
        int cyc = 0;
        int hrun = -1;
        int vrun = -1;
        int last_cs = -1;
        bit phs = 1'b1;
        bit pvs = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (q_d.size() > 0) begin
                e = q_d.pop_front();
                chk("d.CounterX", dx, e.x);
                chk("d.CounterY", dy, e.y);
                chk("d.hsync", dhs, e.hs);
                chk("d.vsync", dvs, e.vs);
                chk("d.inDisplayArea", dde, e.de);
                chk("d.calc_start", dcs, e.cs);
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("s.CounterX", sx, e.x);
                chk("s.CounterY", sy, e.y);
                chk("s.hsync", shs, e.hs);
                chk("s.vsync", svs, e.vs);
                chk("s.inDisplayArea", sde, e.de);
                chk("s.calc_start", scs, e.cs);
            end
            if (reset) begin
                hrun = -1; vrun = -1; last_cs = -1;
                phs = 1'b1; pvs = 1'b0;
            end else begin
                if (!dhs) hrun = phs ? 1 : (hrun >= 0 ? hrun + 1 : -1);
                else if (!phs && hrun > 0) chk("d.hsync_low_width", hrun, 96);
                phs = dhs;
                if (svs) vrun = !pvs ? 1 : (vrun >= 0 ? vrun + 1 : -1);
                else if (pvs && vrun > 0) chk("s.vsync_high_width", vrun, S_VS * S_HT);
                pvs = svs;
                if (scs) begin
                    if (last_cs >= 0) chk("s.calc_start_period", cyc - last_cs, S_HT * S_VT);
                    last_cs = cyc;
                end
            end
        end
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in clocks.
REQ-004 Parameter H_BACK, 48, horizontal back porch in clocks; H_TOTAL = sum of the four = 800.
REQ-005 Parameter V_VISIBLE, 400, visible lines per frame.
REQ-006 Parameter V_FRONT, 12, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 35, vertical back porch in lines; V_TOTAL = sum of the four = 449.
REQ-009 clock  in  1  pixel clock; the block's one clock, all logic on its rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 CounterX  out  10  current pixel column, 0..H_TOTAL-1.
REQ-012 CounterY  out  9  current line, 0..V_TOTAL-1.
REQ-013 hsync  out  1  horizontal sync, active low.
REQ-014 vsync  out  1  vertical sync, active high.
REQ-015 inDisplayArea  out  1  high while (CounterX,CounterY) is visible.
REQ-016 calc_start  out  1  one-clock frame tick for the ball-position stage.

Function
REQ-017 CounterX SHALL increment by 1 every clock; from H_TOTAL-1 it SHALL wrap to 0.
REQ-018 CounterY SHALL increment by 1 only on the clock where CounterX wraps; from V_TOTAL-1 (with CounterX = H_TOTAL-1) both SHALL wrap to 0 on the same clock.
REQ-019 All outputs SHALL be registers; hsync, vsync, inDisplayArea, calc_start SHALL be decoded from next-state counter values so they align with the CounterX/CounterY on the same cycle (zero relative latency).
REQ-020 hsync SHALL be 0 iff H_VISIBLE+H_FRONT <= CounterX < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
REQ-021 vsync SHALL be 1 iff V_VISIBLE+V_FRONT <= CounterY < V_VISIBLE+V_FRONT+V_SYNC (412..413), for the whole line, else 0.
REQ-022 inDisplayArea SHALL be 1 iff CounterX < H_VISIBLE and CounterY < V_VISIBLE.
REQ-023 calc_start SHALL be 1 for exactly one clock per frame, when CounterX = 0 and CounterY = V_VISIBLE (first clock of vertical blanking); 0 otherwise.
REQ-024 Counter comparisons SHALL be unsigned at counter width; no counter value outside its range SHALL ever be produced.

Reset
REQ-025 While reset is high at a rising edge, next state SHALL be CounterX=0, CounterY=0, hsync=1, vsync=0, inDisplayArea=1, calc_start=0.
REQ-026 Reset SHALL take priority over counting at any point in the frame; the first clock after reset deasserts SHALL advance CounterX to 1.
REQ-027 No output SHALL glitch or pulse calc_start as a result of reset entry or exit.

Configuration
REQ-028 Macro VGA_SYNC_PIPE_DELAY_EN: when defined, hsync, vsync and inDisplayArea SHALL pass through one extra register stage (one clock later than CounterX/CounterY), aligning them with the registered draw_ball of the ball-position stage; delayed registers reset to hsync=1, vsync=0, inDisplayArea=0.
REQ-029 When VGA_SYNC_PIPE_DELAY_EN is not defined, REQ-019 alignment applies unchanged; calc_start and counters are unaffected by the macro in both cases.

Verification
REQ-030 Reset held 3 clocks mid-frame at (300,200) -> during reset outputs equal REQ-025 values; first clock after release CounterX=1, CounterY=0.
REQ-031 Run 800 clocks from (0,0) -> CounterX 799 then 0, CounterY 0 then 1; inDisplayArea falls at CounterX=640.
REQ-032 One full line -> hsync low for exactly 96 consecutive clocks, CounterX 656..751.
REQ-033 Two frames -> calc_start pulses exactly 359200 clocks apart, each one clock wide at (0,400).
REQ-034 One frame -> vsync high for exactly 1600 consecutive clocks (lines 412,413); wrap from (799,448) to (0,0).
REQ-035 With VGA_SYNC_PIPE_DELAY_EN defined -> hsync falls at CounterX=657 and inDisplayArea falls at CounterX=641.
